// File: rtl/bin_bcd_pkg.sv
// Shared types and elaboration-time helpers for the bin_bcd converter.
package bin_bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Each decimal digit needs at least log2(10) > 3 bits, so n/3+1 digits always holds the value.
  function automatic int dig_int(input int size_bin);
    return size_bin / 3 + 1;
  endfunction

  function automatic int cnt_width(input int size_bin);
    return $clog2(size_bin + 1);
  endfunction

  function automatic logic [63:0] pow10_minus1(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

endpackage

// File: rtl/bin_bcd_digit_adj.sv
// Double-dabble correction cell: one BCD digit, add 3 when the digit is 5 or more.
module bcd_digit_adj (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;

endmodule

// File: rtl/bin_bcd.sv
// Iterative binary-to-packed-BCD converter, one input bit per clock (double dabble).
// Build option BIN_BCD_SAT_EN: saturate data_bcd to all nines when the value does not fit.
module bin_bcd
  import bin_bcd_pkg::*;
#(
  parameter int SIZE_bin = 24,
  parameter int SIZE_bcd = 28
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [SIZE_bin-1:0] data_bin,
  output logic                busy,
  output logic [SIZE_bcd-1:0] data_bcd,
  output logic                valid,
  output logic                overflow
);

  localparam int          NDIG    = SIZE_bcd / 4;
  localparam int          DIG_INT = dig_int(SIZE_bin);
  localparam int          ACC_W   = 4 * DIG_INT;
  localparam int          CNT_W   = cnt_width(SIZE_bin);
  localparam logic [63:0] THR     = pow10_minus1(NDIG);

  // Handshake: start is honoured only in IDLE; busy spans accept edge to result edge;
  // valid is a one-cycle pulse that coincides with a fresh data_bcd/overflow.
  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [SIZE_bin-1:0]   sh_q, sh_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic                  ovf_int_q, ovf_int_d;
  logic [SIZE_bcd-1:0]   bcd_q, bcd_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  overflow_q, overflow_d;

  logic [ACC_W-1:0]          acc_adj;
  logic [ACC_W+SIZE_bin-1:0] shifted;
  logic [SIZE_bcd-1:0]       trunc;
  logic [SIZE_bcd-1:0]       result;

  for (genvar g = 0; g < DIG_INT; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_i (acc_q[g*4 +: 4]),
      .d_o (acc_adj[g*4 +: 4])
    );
  end

  if (ACC_W >= SIZE_bcd) begin : g_trunc_slice
    assign trunc = acc_q[SIZE_bcd-1:0];
  end else begin : g_trunc_pad
    assign trunc = {{(SIZE_bcd-ACC_W){1'b0}}, acc_q};
  end

`ifdef BIN_BCD_SAT_EN
  assign result = ovf_int_q ? {NDIG{4'h9}} : trunc;
`else
  assign result = trunc;
`endif

  assign shifted = {acc_adj, sh_q} << 1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    acc_d      = acc_q;
    ovf_int_d  = ovf_int_q;
    bcd_d      = bcd_q;
    valid_d    = 1'b0;
    busy_d     = busy_q;
    overflow_d = overflow_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sh_d      = data_bin;
          acc_d     = '0;
          cnt_d     = '0;
          ovf_int_d = (64'(data_bin) > THR);
          busy_d    = 1'b1;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        {acc_d, sh_d} = shifted;
        cnt_d         = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(SIZE_bin - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        bcd_d      = result;
        overflow_d = ovf_int_q;
        valid_d    = 1'b1;
        busy_d     = 1'b0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      acc_q      <= '0;
      ovf_int_q  <= 1'b0;
      bcd_q      <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      acc_q      <= acc_d;
      ovf_int_q  <= ovf_int_d;
      bcd_q      <= bcd_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = busy_q;
  assign data_bcd = bcd_q;
  assign valid    = valid_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bin_bcd.sv
// Bench for bin_bcd: decimal reference model plus deadline-based timing model, checked every cycle.
module tb_bin_bcd;

  localparam int              SIZE_BIN = 24;
  localparam int              SIZE_BCD = 28;
  localparam int              NDIG     = 7;
  localparam longint unsigned LIMIT    = 64'd9999999;
  localparam int              LAT      = SIZE_BIN + 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [SIZE_BIN-1:0] data_bin = '0;
  logic                busy;
  logic [SIZE_BCD-1:0] data_bcd;
  logic                valid;
  logic                overflow;

  int checks = 0;
  int errors = 0;

  bin_bcd #(.SIZE_bin(SIZE_BIN), .SIZE_bcd(SIZE_BCD)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .data_bin (data_bin),
    .busy     (busy),
    .data_bcd (data_bcd),
    .valid    (valid),
    .overflow (overflow)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [SIZE_BCD-1:0] model_bcd(input longint unsigned v);
    longint unsigned         t;
    logic [SIZE_BCD-1:0]     r;
    t = v;
    r = '0;
`ifdef BIN_BCD_SAT_EN
    if (v > LIMIT) return {NDIG{4'h9}};
`endif
    for (int i = 0; i < NDIG; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Timing model: an accepted request resolves LAT edges later; requests during that window are dropped.
  longint              cyc = 0;
  longint              done_edge = 0;
  bit                  m_active = 0;
  logic                m_busy = 0;
  logic                m_valid = 0;
  logic [SIZE_BCD-1:0] m_bcd = '0;
  logic                m_ovf = 0;
  logic [SIZE_BCD-1:0] exp_q[$];
  logic                exp_ovf_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 0;
      m_busy   = 0;
      m_valid  = 0;
      m_bcd    = '0;
      m_ovf    = 0;
      exp_q.delete();
      exp_ovf_q.delete();
    end else begin
      cyc++;
      m_valid = 0;
      if (m_active && cyc == done_edge) begin
        m_active = 0;
        m_busy   = 0;
        m_valid  = 1;
        m_bcd    = exp_q.pop_front();
        m_ovf    = exp_ovf_q.pop_front();
      end else if (!m_active && start) begin
        m_active  = 1;
        m_busy    = 1;
        done_edge = cyc + LAT;
        exp_q.push_back(model_bcd(longint'(data_bin)));
        exp_ovf_q.push_back(longint'(data_bin) > LIMIT);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (busy !== m_busy) begin
        errors++;
        $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, m_busy);
      end
      checks++;
      if (valid !== m_valid) begin
        errors++;
        $display("FAIL valid cyc=%0d got=%b exp=%b", cyc, valid, m_valid);
      end
      checks++;
      if (data_bcd !== m_bcd) begin
        errors++;
        $display("FAIL data_bcd cyc=%0d got=%h exp=%h", cyc, data_bcd, m_bcd);
      end
      checks++;
      if (overflow !== m_ovf) begin
        errors++;
        $display("FAIL overflow cyc=%0d got=%b exp=%b", cyc, overflow, m_ovf);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic convert(input logic [SIZE_BIN-1:0] v, input bit has_lit,
                         input logic [SIZE_BCD-1:0] lit_bcd, input logic lit_ovf,
                         input string name);
    int busy_cnt;
    int waited;
    @(negedge clk);
    start    = 1'b1;
    data_bin = v;
    @(negedge clk);
    start    = 1'b0;
    data_bin = SIZE_BIN'($urandom);
    busy_cnt = 0;
    waited   = 0;
    while (!valid && waited < 60) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      waited++;
    end
    if (!valid) begin
      errors++;
      checks++;
      $display("FAIL %s_timeout got=no_valid exp=valid_within_60", name);
    end else if (has_lit) begin
      check_val({name, "_bcd"}, 64'(data_bcd), 64'(lit_bcd));
      check_val({name, "_ovf"}, 64'(overflow), 64'(lit_ovf));
      check_val({name, "_busy_len"}, 64'(busy_cnt), 64'(LAT));
      check_val({name, "_busy_at_valid"}, 64'(busy), 64'd0);
      @(negedge clk);
      check_val({name, "_valid_width"}, 64'(valid), 64'd0);
    end
  endtask

  task automatic run_back_to_back();
    int last;
    int n;
    int t;
    last = -1;
    n    = 0;
    t    = 0;
    @(negedge clk);
    start    = 1'b1;
    data_bin = SIZE_BIN'($urandom_range(0, 32'hFFFFFF));
    while (n < 4 && t < 200) begin
      @(negedge clk);
      t++;
      data_bin = SIZE_BIN'($urandom_range(0, 32'hFFFFFF));
      if (valid) begin
        if (last >= 0) check_val("b2b_spacing", 64'(t - last), 64'(LAT + 1));
        last = t;
        n++;
      end
    end
    start = 1'b0;
    if (n < 4) begin
      errors++;
      checks++;
      $display("FAIL b2b_timeout got=%0d exp=4", n);
    end
  endtask

  task automatic run_reset_abort();
    int seen;
    @(negedge clk);
    start    = 1'b1;
    data_bin = 24'd500;
    @(negedge clk);
    start    = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_valid", 64'(valid), 64'd0);
    check_val("rst_bcd", 64'(data_bcd), 64'd0);
    check_val("rst_ovf", 64'(overflow), 64'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (valid) seen++;
    end
    check_val("rst_no_valid", 64'(seen), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [SIZE_BIN-1:0] v;
    repeat (3) @(negedge clk);
    check_val("reset_busy", 64'(busy), 64'd0);
    check_val("reset_valid", 64'(valid), 64'd0);
    check_val("reset_bcd", 64'(data_bcd), 64'd0);
    check_val("reset_ovf", 64'(overflow), 64'd0);
    rst = 1'b0;

    convert(24'd12345,   1, 28'h0012345, 1'b0, "d12345");
    convert(24'd9999999, 1, 28'h9999999, 1'b0, "d9999999");
    convert(24'd0,       1, 28'h0000000, 1'b0, "zero");
    convert(24'd1,       1, 28'h0000001, 1'b0, "one");
    convert(24'd8640000, 1, 28'h8640000, 1'b0, "d8640000");
`ifdef BIN_BCD_SAT_EN
    convert(24'hFFFFFF,  1, 28'h9999999, 1'b1, "max");
    convert(24'd10000000, 1, 28'h9999999, 1'b1, "d1e7");
`else
    convert(24'hFFFFFF,  1, 28'h6777215, 1'b1, "max");
    convert(24'd10000000, 1, 28'h0000000, 1'b1, "d1e7");
`endif
    convert(24'd65535,   1, 28'h0065535, 1'b0, "d65535");

    run_back_to_back();
    repeat (30) @(negedge clk);

    convert(24'd777, 1, 28'h0000777, 1'b0, "pre_rst");
    run_reset_abort();
    convert(24'd42, 1, 28'h0000042, 1'b0, "after_rst");

    for (int i = 0; i < 1000; i++) begin
      case (i % 4)
        0:       v = SIZE_BIN'($urandom_range(0, 99));
        1:       v = SIZE_BIN'($urandom_range(9999000, 10001000));
        default: v = SIZE_BIN'($urandom_range(0, 32'hFFFFFF));
      endcase
      convert(v, 0, '0, 1'b0, "rand");
    end

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
